// File: rtl/decode_stage_hs_pkg.sv
// decode_stage_hs_pkg: RV32I opcode/control encodings plus control decode and immediate extend helpers.
package decode_stage_hs_pkg;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_OP = 7'b0110011,
                         OP_IMM = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [1:0] RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2;
  localparam logic [1:0] MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_LUI = 4'd10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [1:0] mem_size;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Unknown opcodes fall out as all-zero controls; trapping is done further down the pipe.
  function automatic ctrl_t control_unit(input logic [31:0] i);
    ctrl_t c;
    c = '0;
    case (i[6:0])
      OP_LOAD:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = RES_MEM; c.mem_size = i[13:12]; end
      OP_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.mem_size = i[13:12]; end
      OP_OP:     begin c.reg_write = 1'b1; c.alu_ctrl = alu_op(i[14:12], i[30]); end
      OP_IMM:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_ctrl = alu_op(i[14:12], i[14:12] == 3'b101 && i[30]); end
      OP_BRANCH: begin c.branch = 1'b1; c.alu_ctrl = ALU_SUB; end
      OP_JAL:    begin c.reg_write = 1'b1; c.jump = 1'b1; c.result_src = RES_PC4; end
      OP_JALR:   begin c.reg_write = 1'b1; c.jump = 1'b1; c.alu_src = 1'b1; c.result_src = RES_PC4; end
      OP_LUI:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_ctrl = ALU_LUI; end
      OP_AUIPC:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OP_OP || op == OP_STORE || op == OP_BRANCH;
  endfunction

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    return op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B : op == OP_JAL ? IMM_J :
           (op == OP_LUI || op == OP_AUIPC) ? IMM_U : IMM_I;
  endfunction

  function automatic logic [31:0] imm_extend(input logic [31:0] i);
    case (imm_src(i[6:0]))
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_hs_regfile_bypass.sv
// regfile_bypass: 2**RA_W x XLEN register file, x0 hardwired to zero, optional same-cycle WB bypass.
module regfile_bypass #(
  parameter int RA_W      = 5,
  parameter int XLEN      = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic            clk,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [XLEN-1:0] wd,
  input  logic [RA_W-1:0] ra1,
  input  logic [RA_W-1:0] ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] mem [2**RA_W];
  logic wr;
  assign wr = we && wa != '0;
  always_ff @(posedge clk) begin
    if (wr) mem[wa] <= wd;
  end
  assign rd1 = ra1 == '0 ? '0 : (BYPASS_EN != 0 && wr && wa == ra1) ? wd : mem[ra1];
  assign rd2 = ra2 == '0 ? '0 : (BYPASS_EN != 0 && wr && wa == ra2) ? wd : mem[ra2];
endmodule

// File: rtl/decode_stage_hs.sv
// decode_stage_hs: register read, control decode and immediate extend feeding a valid/ready ID/EX register
// with load-use bubble insertion and flush.
module decode_stage_hs
  import decode_stage_hs_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int BYPASS_EN = 1,
  parameter int LU_DETECT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] pcD,
  input  logic [XLEN-1:0] pc_plus4D,
  input  logic            RegWriteW,
  input  logic [RA_W-1:0] RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [1:0]      MemSizeE,
  output logic [3:0]      ALUCtrlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] pcE,
  output logic [XLEN-1:0] ExtImmE,
  output logic [XLEN-1:0] pc_plus4E,
  output logic [RA_W-1:0] Rs1E,
  output logic [RA_W-1:0] Rs2E,
  output logic [RA_W-1:0] RdE,
  output logic            lu_stall
);
  typedef struct packed {
    logic            valid;
    ctrl_t           ctrl;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, pc, imm, pc4;
  } ex_t;

  ex_t ex_q, ex_d, ex_n;
  logic [RA_W-1:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rd1_d, rd2_d;
  logic lu, advance;

  assign rs1_d = RA_W'(instrD[19:15]);
  assign rs2_d = RA_W'(instrD[24:20]);
  assign rd_d  = RA_W'(instrD[11:7]);

  regfile_bypass #(.RA_W(RA_W), .XLEN(XLEN), .BYPASS_EN(BYPASS_EN)) u_rf (
    .clk(clk), .we(RegWriteW), .wa(RdW), .wd(ResultW),
    .ra1(rs1_d), .ra2(rs2_d), .rd1(rd1_d), .rd2(rd2_d)
  );

  // A load in E whose destination is read by D must be followed by one bubble.
  always_comb begin
    lu = LU_DETECT != 0 && in_valid && ex_q.valid && ex_q.ctrl.result_src == RES_MEM && ex_q.rd != '0 &&
         (ex_q.rd == rs1_d || (ex_q.rd == rs2_d && uses_rs2(instrD[6:0])));
    advance = !ex_q.valid || out_ready;
    ex_n = '{valid: 1'b1, ctrl: control_unit(instrD), rs1: rs1_d, rs2: rs2_d, rd: rd_d,
             rd1: rd1_d, rd2: rd2_d, pc: pcD, imm: XLEN'($signed(imm_extend(instrD))), pc4: pc_plus4D};
    ex_d = FlushE ? '0 : !advance ? ex_q : (in_valid && !lu) ? ex_n : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign in_ready   = advance && !lu && !FlushE;
  assign lu_stall   = lu;
  assign out_valid  = ex_q.valid;
  assign RegWriteE  = ex_q.ctrl.reg_write;
  assign MemWriteE  = ex_q.ctrl.mem_write;
  assign JumpE      = ex_q.ctrl.jump;
  assign BranchE    = ex_q.ctrl.branch;
  assign ALUSrcE    = ex_q.ctrl.alu_src;
  assign ResultSrcE = ex_q.ctrl.result_src;
  assign MemSizeE   = ex_q.ctrl.mem_size;
  assign ALUCtrlE   = ex_q.ctrl.alu_ctrl;
  assign RD1E       = ex_q.rd1;
  assign RD2E       = ex_q.rd2;
  assign pcE        = ex_q.pc;
  assign ExtImmE    = ex_q.imm;
  assign pc_plus4E  = ex_q.pc4;
  assign Rs1E       = ex_q.rs1;
  assign Rs2E       = ex_q.rs2;
  assign RdE        = ex_q.rd;
endmodule

// File: tb/tb_decode_stage_hs.sv
// tb_decode_stage_hs: directed scenarios for the decode stage with hand-computed expectations.
module tb_decode_stage_hs;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, RegWriteW = 1'b0, FlushE = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] instrD = '0, pcD = '0, pc_plus4D = '0, ResultW = '0;
  logic [4:0] RdW = '0, Rs1E, Rs2E, RdE;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, lu_stall;
  logic [1:0] ResultSrcE, MemSizeE;
  logic [3:0] ALUCtrlE;
  logic [31:0] RD1E, RD2E, pcE, ExtImmE, pc_plus4E;
  int tests = 0, fails = 0;

  decode_stage_hs dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instrD(instrD), .pcD(pcD),
    .pc_plus4D(pc_plus4D), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .out_valid(out_valid), .out_ready(out_ready), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .MemSizeE(MemSizeE),
    .ALUCtrlE(ALUCtrlE), .RD1E(RD1E), .RD2E(RD2E), .pcE(pcE), .ExtImmE(ExtImmE), .pc_plus4E(pc_plus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .lu_stall(lu_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    instrD = ins;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %h exp 0", out_valid); end
    tests++; if (RD1E !== 32'h0) begin fails++; $display("FAIL reset_rd1 got %h exp 0", RD1E); end
    tests++; if (RegWriteE !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %h exp 0", RegWriteE); end
    @(negedge clk);
    rst = 1'b1;
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'd100;
    tick();
    RdW = 5'd2; ResultW = 32'd200;
    tick();
    RegWriteW = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(addi(5'd3, 5'd1, 12'd5)); pcD = 32'h100; pc_plus4D = 32'h104;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %h exp 1", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid0 got %h exp 1", out_valid); end
    tests++; if (RD1E !== 32'd100) begin fails++; $display("FAIL b2b_rd1_0 got %h exp 64", RD1E); end
    tests++; if (ExtImmE !== 32'd5) begin fails++; $display("FAIL b2b_imm0 got %h exp 5", ExtImmE); end
    tests++; if ({RegWriteE, ALUSrcE, RdE} !== {1'b1, 1'b1, 5'd3}) begin fails++; $display("FAIL b2b_ctrl0 got %b%b %0d exp 11 3", RegWriteE, ALUSrcE, RdE); end
    tests++; if ({pcE, pc_plus4E} !== {32'h100, 32'h104}) begin fails++; $display("FAIL b2b_pc got %h %h exp 100 104", pcE, pc_plus4E); end
    issue(addi(5'd4, 5'd2, 12'hFFF)); pcD = 32'h104; pc_plus4D = 32'h108;
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid1 got %h exp 1", out_valid); end
    tests++; if (RD1E !== 32'd200) begin fails++; $display("FAIL b2b_rd1_1 got %h exp c8", RD1E); end
    tests++; if (ExtImmE !== 32'hFFFFFFFF) begin fails++; $display("FAIL b2b_imm1 got %h exp ffffffff", ExtImmE); end
    tests++; if (RdE !== 5'd4) begin fails++; $display("FAIL b2b_rd1 got %0d exp 4", RdE); end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %h exp 0", out_valid); end
  endtask

  task automatic test_bypass();
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
    issue(add(5'd6, 5'd5, 5'd1));
    tick();
    tests++; if (RD1E !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_rd1 got %h exp deadbeef", RD1E); end
    tests++; if (RD2E !== 32'd100) begin fails++; $display("FAIL bypass_rd2 got %h exp 64", RD2E); end
    RdW = 5'd0; ResultW = 32'h1234;
    issue(add(5'd6, 5'd0, 5'd5));
    tick();
    tests++; if (RD1E !== 32'h0) begin fails++; $display("FAIL bypass_x0 got %h exp 0", RD1E); end
    tests++; if (RD2E !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_stored got %h exp deadbeef", RD2E); end
    RegWriteW = 1'b0;
    issue(addi(5'd6, 5'd0, 12'd0));
    tick();
    tests++; if (RD1E !== 32'h0) begin fails++; $display("FAIL x0_after_write got %h exp 0", RD1E); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    issue(lw(5'd7, 5'd1, 12'd4));
    tick();
    tests++; if ({out_valid, ResultSrcE, MemSizeE, RdE} !== {1'b1, 2'd1, 2'd2, 5'd7}) begin fails++; $display("FAIL lw_issue got %b %0d %0d %0d exp 1 1 2 7", out_valid, ResultSrcE, MemSizeE, RdE); end
    tests++; if (ExtImmE !== 32'd4) begin fails++; $display("FAIL lw_imm got %h exp 4", ExtImmE); end
    issue(add(5'd8, 5'd7, 5'd1));
    #1;
    tests++; if (lu_stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %h exp 1", lu_stall); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL lu_in_ready got %h exp 0", in_ready); end
    tick();
    tests++; if ({out_valid, RegWriteE} !== 2'b00) begin fails++; $display("FAIL lu_bubble got %b%b exp 00", out_valid, RegWriteE); end
    tests++; if ({lu_stall, in_ready} !== 2'b01) begin fails++; $display("FAIL lu_release got %b%b exp 01", lu_stall, in_ready); end
    tick();
    tests++; if ({out_valid, RdE, Rs1E} !== {1'b1, 5'd8, 5'd7}) begin fails++; $display("FAIL lu_add_issue got %b %0d %0d exp 1 8 7", out_valid, RdE, Rs1E); end
    issue(lw(5'd7, 5'd1, 12'd4));
    tick();
    issue(add(5'd8, 5'd1, 5'd2));
    #1;
    tests++; if (lu_stall !== 1'b0) begin fails++; $display("FAIL no_lu_stall got %h exp 0", lu_stall); end
    tick();
    tests++; if ({out_valid, RdE, RD2E} !== {1'b1, 5'd8, 32'd200}) begin fails++; $display("FAIL no_lu_issue got %b %0d %h exp 1 8 c8", out_valid, RdE, RD2E); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    issue(addi(5'd9, 5'd1, 12'd1));
    tick();
    out_ready = 1'b0;
    issue(addi(5'd10, 5'd2, 12'd2));
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready%0d got %h exp 0", i, in_ready); end
      tick();
      tests++; if ({out_valid, RdE, ExtImmE, RD1E} !== {1'b1, 5'd9, 32'd1, 32'd100}) begin fails++; $display("FAIL bp_hold%0d got %b %0d %h %h exp 1 9 1 64", i, out_valid, RdE, ExtImmE, RD1E); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_resume got %h exp 1", in_ready); end
    tick();
    tests++; if ({out_valid, RdE, ExtImmE, RD1E} !== {1'b1, 5'd10, 32'd2, 32'd200}) begin fails++; $display("FAIL bp_next got %b %0d %h %h exp 1 10 2 c8", out_valid, RdE, ExtImmE, RD1E); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    issue(sw(5'd2, 5'd1, 12'd8));
    tick();
    tests++; if ({out_valid, MemWriteE, RegWriteE, ExtImmE, RD2E} !== {3'b110, 32'd8, 32'd200}) begin fails++; $display("FAIL sw_issue got %b%b%b %h %h exp 110 8 c8", out_valid, MemWriteE, RegWriteE, ExtImmE, RD2E); end
    FlushE = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %h exp 0", in_ready); end
    tick();
    tests++; if ({out_valid, MemWriteE} !== 2'b00) begin fails++; $display("FAIL flush got %b%b exp 00", out_valid, MemWriteE); end
    FlushE = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    issue(addi(5'd3, 5'd1, 12'd5));
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ar_pre got %h exp 1", out_valid); end
    rst = 1'b0;
    #1;
    tests++; if ({out_valid, RegWriteE, ALUSrcE} !== 3'b000) begin fails++; $display("FAIL ar_ctrl got %b%b%b exp 000", out_valid, RegWriteE, ALUSrcE); end
    tests++; if ({RD1E, ExtImmE, pcE} !== 96'h0) begin fails++; $display("FAIL ar_data got %h %h %h exp 0 0 0", RD1E, ExtImmE, pcE); end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tests++; if ({out_valid, RdE} !== 6'b0) begin fails++; $display("FAIL ar_after got %b %0d exp 0 0", out_valid, RdE); end
    issue(addi(5'd3, 5'd1, 12'd5));
    tick();
    tests++; if ({out_valid, RD1E} !== {1'b1, 32'd100}) begin fails++; $display("FAIL ar_reissue got %b %h exp 1 64", out_valid, RD1E); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
